// File: rtl/button_pulse_conditioner.sv
// Synchronise, debounce and pulse-convert the up/down pushbuttons for the hex counter.
// Optional auto-repeat while a button is held: define AUTOREPEAT_EN.
module button_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_pulse_conditioner: illegal parameter value");
  end

  logic [1:0] raw;
  logic [1:0] ev;
  logic [1:0] level;

  assign raw = {btn_dec_raw, btn_inc_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [1:0]    sync_q;
    logic          synced;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q;
    logic          press;
    logic          rep;

    assign synced = sync_q[1];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
      case (state_q)
        ST_LOW: begin
          if (synced) begin
            state_d = ST_WAIT_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (!synced) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_FULL;
            press   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!synced) begin
            state_d = ST_WAIT_LOW;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          if (synced) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            cnt_d   = CNT_FULL;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

`ifdef AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_ONE         = RW'(1);
    localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          again_q, again_d;

    // Counter only runs while the channel stays in ST_HIGH; any other state clears it.
    always_comb begin
      rpt_d   = '0;
      again_d = 1'b0;
      rep     = 1'b0;
      if (state_q == ST_HIGH && state_d == ST_HIGH) begin
        if (rpt_q == (again_q ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
          rep     = 1'b1;
          again_d = 1'b1;
        end else begin
          rpt_d   = rpt_q + RPT_ONE;
          again_d = again_q;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rpt_q   <= '0;
        again_q <= 1'b0;
      end else begin
        rpt_q   <= rpt_d;
        again_q <= again_d;
      end
    end
`else
    assign rep = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q  <= '0;
        state_q <= ST_LOW;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], raw[ch]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
      end
    end

    assign ev[ch]    = press | rep;
    assign level[ch] = level_q;
  end

  logic inc_pulse_q, inc_pulse_d;
  logic dec_pulse_q, dec_pulse_d;

  // Coincident inc/dec events cancel each other so the counter never sees both.
  assign inc_pulse_d = ev[0] & ~ev[1];
  assign dec_pulse_d = ev[1] & ~ev[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
    end else begin
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
    end
  end

  assign inc_pulse = inc_pulse_q;
  assign dec_pulse = dec_pulse_q;
  assign inc_level = level[0];
  assign dec_level = level[1];

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with short debounce/repeat timing.
module tb_button_pulse_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

`ifdef AUTOREPEAT_EN
  localparam int EXP_CLEAN = 5;
`else
  localparam int EXP_CLEAN = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_inc_raw = 1'b1;
  logic btn_dec_raw = 1'b1;
  logic inc_pulse, dec_pulse, inc_level, dec_level;

  always #5 clk = ~clk;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  int cyc = 0;
  int inc_edges[$];
  int dec_edges[$];
  int overlaps = 0;
  int n_total = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log the edge index after which each pulse is visible.
  always @(posedge clk) begin
    #1;
    if (inc_pulse) inc_edges.push_back(cyc);
    if (dec_pulse) dec_edges.push_back(cyc);
    if (inc_pulse && dec_pulse) overlaps++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic int outs();
    return int'({inc_pulse, dec_pulse, inc_level, dec_level});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r, ni, nd, rise;
    int pat[8];
    int offs[7];
    pat  = '{1, 1, 1, 0, 1, 1, 0, 1};
    offs = '{0, 10, 15, 20, 25, 30, 35};

    // Reset with both buttons held: simultaneous press dropped, levels rise.
    tick(3);
    chk("rst_outs", outs(), 0);
    e = cyc;
    reset = 1'b0;
    tick(5);
    chk("rst_lvl_early", int'({inc_level, dec_level}), 0);
    tick(1);
    chk("rst_lvl", int'({inc_level, dec_level}), 3);
    tick(3);
    chk("rst_inc_pulses", inc_edges.size(), 0);
    chk("rst_dec_pulses", dec_edges.size(), 0);
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    tick(8);
    chk("rel_lvl", int'({inc_level, dec_level}), 0);

    // Clean press held 30 cycles.
    ni = inc_edges.size();
    nd = dec_edges.size();
    e = cyc;
    btn_inc_raw = 1'b1;
    tick(5);
    chk("clean_lvl_early", int'(inc_level), 0);
    chk("clean_nopulse", int'(inc_pulse), 0);
    tick(1);
    chk("clean_pulse", int'(inc_pulse), 1);
    chk("clean_lvl", int'(inc_level), 1);
    chk("clean_edge", (inc_edges.size() > ni) ? inc_edges[ni] : -1, e + 6);
    tick(1);
    chk("clean_width", int'(inc_pulse), 0);
    tick(23);
    btn_inc_raw = 1'b0;
    tick(5);
    chk("clean_rel_lvl_early", int'(inc_level), 1);
    tick(1);
    chk("clean_rel_lvl", int'(inc_level), 0);
    tick(4);
    chk("clean_count", inc_edges.size() - ni, EXP_CLEAN);
    chk("clean_dec_none", dec_edges.size() - nd, 0);

    // Bounce on dec, then a stable hold.
    nd = dec_edges.size();
    rise = 0;
    for (int i = 0; i < 8; i++) begin
      btn_dec_raw = pat[i][0];
      rise = cyc;
      tick(1);
    end
    tick(4);
    chk("bounce_none", dec_edges.size() - nd, 0);
    tick(1);
    chk("bounce_pulse", int'(dec_pulse), 1);
    chk("bounce_edge", (dec_edges.size() > nd) ? dec_edges[nd] : -1, rise + 6);
    tick(5);
    chk("bounce_count", dec_edges.size() - nd, 1);
    btn_dec_raw = 1'b0;
    tick(8);

    // Simultaneous press.
    ni = inc_edges.size();
    nd = dec_edges.size();
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    tick(10);
    chk("simul_inc", inc_edges.size() - ni, 0);
    chk("simul_dec", dec_edges.size() - nd, 0);
    chk("simul_lvl", int'({inc_level, dec_level}), 3);
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    tick(8);

    // Staggered press by one cycle.
    btn_inc_raw = 1'b1;
    tick(1);
    btn_dec_raw = 1'b1;
    tick(5);
    chk("stag_a", int'({inc_pulse, dec_pulse}), 2);
    tick(1);
    chk("stag_b", int'({inc_pulse, dec_pulse}), 1);
    tick(1);
    chk("stag_c", int'({inc_pulse, dec_pulse}), 0);
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    tick(8);

    // Reset mid-debounce with the button still held.
    ni = inc_edges.size();
    btn_inc_raw = 1'b1;
    tick(3);
    reset = 1'b1;
    #1;
    chk("midrst_outs", outs(), 0);
    tick(1);
    reset = 1'b0;
    r = cyc;
    tick(5);
    chk("midrst_none", inc_edges.size() - ni, 0);
    tick(1);
    chk("midrst_pulse", int'(inc_pulse), 1);
    chk("midrst_edge", (inc_edges.size() > ni) ? inc_edges[ni] : -1, r + 6);
    btn_inc_raw = 1'b0;
    tick(8);

    // Long hold: auto-repeat train when enabled, single pulse otherwise.
    ni = inc_edges.size();
    e = cyc;
    btn_inc_raw = 1'b1;
    tick(40);
    btn_inc_raw = 1'b0;
    tick(10);
`ifdef AUTOREPEAT_EN
    chk("rep_count", inc_edges.size() - ni, 7);
    for (int j = 0; j < 7; j++)
      chk($sformatf("rep_edge%0d", j),
          (inc_edges.size() > ni + j) ? inc_edges[ni + j] : -1, e + 6 + offs[j]);
`else
    chk("hold_count", inc_edges.size() - ni, 1);
    chk("hold_edge", (inc_edges.size() > ni) ? inc_edges[ni] : -1, e + 6 + offs[0]);
`endif

    chk("overlap_total", overlaps, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/button_pulse_conditioner.md
Name: button_pulse_conditioner

Overview:
Front-end conditioner for the two raw up/down pushbuttons that drive the hex up/down counter.
- Synchronises each button into clk and debounces it.
- Converts each accepted press into a single-cycle increment or decrement pulse.
- Enforces mutual exclusion, so the counter never sees increment and decrement in the same cycle.
- Sits directly between the board pins and the counter's increment/decrement inputs.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles needed to accept a level change (1 ms at 50 MHz); legal range ≥2.
REPEAT_DELAY, 25000000, cycles from the press pulse to the first auto-repeat pulse (only with AUTOREPEAT_EN).
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (only with AUTOREPEAT_EN).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
btn_inc_raw  input  1  raw, asynchronous increment button, active-high.
btn_dec_raw  input  1  raw, asynchronous decrement button, active-high.
inc_pulse  output  1  one-cycle increment request to the counter.
dec_pulse  output  1  one-cycle decrement request to the counter.
inc_level  output  1  debounced state of the increment button.
dec_level  output  1  debounced state of the decrement button.

Behaviour:
- Reset is asynchronous, active-high; clock is clk. Reset mid-operation aborts any debounce or repeat in progress.
- While reset is high, each channel holds these values:
  - synchroniser flops = 0
  - state = ST_LOW
  - debounce counter = 0
  - repeat counter = 0
  - all four outputs = 0
- Synchroniser: 2-flop per channel. A raw change sampled at edge k appears at the synchroniser output at edge k+1 and is visible to the FSM from edge k+2.
- Debounce FSM per channel, states ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW:
  - ST_LOW: synced=1 -> ST_WAIT_HIGH, counter=1.
  - ST_WAIT_HIGH: synced=1 -> counter+1; when counter would reach DEBOUNCE_CYCLES -> ST_HIGH and raise a press event. synced=0 -> ST_LOW, counter=0 (glitch rejected).
  - ST_HIGH and ST_WAIT_LOW mirror this for release; release raises no pulse.
  - Counter width = clog2(DEBOUNCE_CYCLES+1). The counter never wraps; it saturates at accept.
- inc_level / dec_level = 1 exactly in ST_HIGH and ST_WAIT_LOW; they are registered state decodes.
- Pulse timing and width:
  - Raw rising at edge k and stable thereafter -> press event at edge k+1+DEBOUNCE_CYCLES.
  - Registered pulse is high during the cycle following that edge.
  - Pulse width is always exactly 1 cycle.
- Mutual exclusion: if inc and dec press/repeat events occur in the same cycle, neither pulse is asserted and both events are dropped. Levels still update.
- One press yields exactly one pulse (absent AUTOREPEAT_EN), however long it is held.
- Button held through reset deassertion: treated as a new press; a pulse is emitted after the normal debounce latency.
- No pulse is ever emitted from ST_WAIT_* states or on release.

Optional Feature:
AUTOREPEAT_EN
- Defined: per channel, a repeat counter runs while the channel is in ST_HIGH.
  - First repeat event fires REPEAT_DELAY cycles after the press pulse.
  - Further repeat events fire every REPEAT_PERIOD cycles until the channel leaves ST_HIGH.
  - Leaving ST_HIGH (entering ST_WAIT_LOW) clears the repeat counter immediately.
  - Repeat events obey the same mutual-exclusion rule.
- Undefined: no repeat counters are synthesised; exactly one pulse per accepted press.

Test Plan:
Reset sequencing (params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5 for all tests) -> reset asserted with both raw inputs=1 -> all outputs 0 throughout reset; raw stays 1, reset released before edge 5 -> inc_pulse and dec_pulse stay 0 (simultaneous drop), inc_level=dec_level=1 from edge 10.
Clean press -> btn_inc_raw 0->1 before edge 10, held 30 cycles -> inc_pulse=1 only in the cycle after edge 15, inc_level=1 from edge 15, dec_pulse never 1; release -> inc_level=0 six edges after release, no pulse.
Bounce rejection -> btn_dec_raw toggles 1,1,1,0,1,1,0,1 (one value per cycle) then holds 1 -> no dec_pulse during bounce; exactly one dec_pulse, 5 edges after the final rising sample.
Simultaneous press -> both raw rise before the same edge and hold -> zero pulses on either output; both levels =1. Staggered press by 1 cycle -> inc_pulse then dec_pulse on consecutive cycles, never overlapping.
Reset mid-debounce -> inc raw high for 3 cycles, reset pulsed 1 cycle, raw held -> no pulse before reset; one pulse at full latency measured from reset release.
AUTOREPEAT_EN defined -> inc held 40 cycles, first pulse at edge P -> pulses at P, P+10, P+15, P+20, P+25, P+30, P+35 (stopping once the channel enters ST_WAIT_LOW); undefined -> single pulse at P only.
